cache_mem_arbiter: RTL and testbench

Shares the single physical-memory port between the I-cache (fed by the IF stage's fetch path) and the D-cache (MEM stage). It grants one full-line read or write transaction at a time and latches the winner's address and write data at grant. It forwards the memory response back to the owning cache only. Fixed D-cache priority applies, with a starvation guard so fetch cannot be locked out indefinitely.

---
 rtl/cache_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbiter for the shared line-wide memory port between the I-cache and the D-cache.
// D-cache has priority; a starvation counter forces an I-cache grant.
module cache_mem_arbiter #(
  parameter int LINE_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic [1:0]            grant_owner,
  output logic                  arb_busy
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D_RD,
    SERVE_D_WR
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nx;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_nx;
  logic [CW-1:0]         starve_cnt, starve_nx;
  logic [1:0]            owner_nx;
  logic                  d_req, d_wins;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      starve_cnt  <= '0;
      grant_owner <= 2'b00;
      arb_busy    <= 1'b0;
    end else begin
      state       <= state_nx;
      addr_q      <= addr_nx;
      wdata_q     <= wdata_nx;
      starve_cnt  <= starve_nx;
      grant_owner <= owner_nx;
      arb_busy    <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx  = state;
    addr_nx   = addr_q;
    wdata_nx  = wdata_q;
    starve_nx = starve_cnt;
    d_req     = d_pmem_read | d_pmem_write;
    d_wins    = d_req && (!i_pmem_read || starve_cnt < LIM);
    unique case (state)
      IDLE: begin
        if (!i_pmem_read)
          starve_nx = '0;
        if (d_wins) begin
          state_nx = d_pmem_write ? SERVE_D_WR : SERVE_D_RD;
          addr_nx  = d_pmem_address;
          wdata_nx = d_pmem_wdata;
          if (i_pmem_read && starve_cnt != LIM)
            starve_nx = starve_cnt + 1'b1;
        end else if (i_pmem_read) begin
          state_nx  = SERVE_I;
          addr_nx   = i_pmem_address;
          starve_nx = '0;
        end
      end
      SERVE_I,
      SERVE_D_RD,
      SERVE_D_WR: begin
        if (pmem_resp)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    owner_nx = 2'b00;
    unique case (1'b1)
      (state_nx == SERVE_I):    owner_nx = 2'b01;
      (state_nx == SERVE_D_RD),
      (state_nx == SERVE_D_WR): owner_nx = 2'b10;
      default:                  owner_nx = 2'b00;
    endcase
  end

  assign pmem_read    = (state == SERVE_I) || (state == SERVE_D_RD);
  assign pmem_write   = (state == SERVE_D_WR);
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // A reset cycle aborts the transfer, so its completion is not forwarded.
  assign i_pmem_resp = (state == SERVE_I) && pmem_resp && !reset;
  assign d_pmem_resp = ((state == SERVE_D_RD) || (state == SERVE_D_WR))
                       && pmem_resp && !reset;

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (!reset && state == IDLE)
      assert (!(d_pmem_read && d_pmem_write))
        else $warning("cache_mem_arbiter: D read and write requested together");
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Randomized bench for cache_mem_arbiter with a transaction-level reference model.
// Bench acts as both caches and the memory.
module tb_cache_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic [LW-1:0] i_pmem_rdata;
  logic          i_pmem_resp;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic [LW-1:0] d_pmem_rdata;
  logic          d_pmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic [1:0]    grant_owner;
  logic          arb_busy;

  cache_mem_arbiter #(
    .LINE_WIDTH  (LW),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_pmem_read   (i_pmem_read),
    .i_pmem_address(i_pmem_address),
    .i_pmem_rdata  (i_pmem_rdata),
    .i_pmem_resp   (i_pmem_resp),
    .d_pmem_read   (d_pmem_read),
    .d_pmem_write  (d_pmem_write),
    .d_pmem_address(d_pmem_address),
    .d_pmem_wdata  (d_pmem_wdata),
    .d_pmem_rdata  (d_pmem_rdata),
    .d_pmem_resp   (d_pmem_resp),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .grant_owner   (grant_owner),
    .arb_busy      (arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } dreq_t;

  logic [AW-1:0] i_q[$];
  dreq_t         d_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int            m_owner = 0;
  int            m_starve = 0;
  bit            m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [LW-1:0] m_wdata = '0;

  int mem_lat = 5;
  int mem_cnt = 0;
  bit got_i, got_d;
  int i_resps = 0, d_resps = 0;
  int last_i_cyc = 0, last_d_cyc = 0;
  int d_at_i = 0;

  task automatic check(string tag, logic [LW-1:0] got, logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {8{$urandom}};
  endfunction

  task automatic drive();
    i_pmem_read = (i_q.size() != 0);
    if (i_q.size() == 0 || m_owner == 1)
      i_pmem_address = $urandom;
    else
      i_pmem_address = i_q[0];
    if (d_q.size() == 0) begin
      d_pmem_read    = 1'b0;
      d_pmem_write   = 1'b0;
      d_pmem_address = $urandom;
      d_pmem_wdata   = rnd_line();
    end else begin
      d_pmem_read  = d_q[0].rd;
      d_pmem_write = d_q[0].wr;
      if (m_owner == 2) begin
        d_pmem_address = $urandom;
        d_pmem_wdata   = rnd_line();
      end else begin
        d_pmem_address = d_q[0].addr;
        d_pmem_wdata   = d_q[0].wdata;
      end
    end
  endtask

  task automatic cycle();
    bit ir, dr, dw, busy;
    cyc++;
    @(negedge clk);
    busy = (m_owner != 0);
    check("grant_owner", LW'(grant_owner), LW'(m_owner));
    check("arb_busy", LW'(arb_busy), LW'(busy));
    check("pmem_read", LW'(pmem_read), LW'(busy && !m_wr));
    check("pmem_write", LW'(pmem_write), LW'(busy && m_wr));
    if (busy)
      check("pmem_address", LW'(pmem_address), LW'(m_addr));
    if (busy && m_wr)
      check("pmem_wdata", pmem_wdata, m_wdata);
    check("i_resp", LW'(i_pmem_resp), LW'(m_owner == 1 && pmem_resp && !reset));
    check("d_resp", LW'(d_pmem_resp), LW'(m_owner == 2 && pmem_resp && !reset));
    check("i_rdata", i_pmem_rdata, pmem_rdata);
    check("d_rdata", d_pmem_rdata, pmem_rdata);
    check("starve_cnt", LW'(dut.starve_cnt), LW'(m_starve));
    got_i = i_pmem_resp;
    got_d = d_pmem_resp;
    if (got_i) begin
      i_resps++;
      last_i_cyc = cyc;
      d_at_i = d_resps;
    end
    if (got_d) begin
      d_resps++;
      last_d_cyc = cyc;
    end
    ir = i_pmem_read;
    dr = d_pmem_read | d_pmem_write;
    dw = d_pmem_write;
    if (reset) begin
      m_owner = 0;
      m_wr = 0;
      m_addr = '0;
      m_wdata = '0;
      m_starve = 0;
    end else if (m_owner != 0) begin
      if (pmem_resp)
        m_owner = 0;
    end else if (dr && (!ir || m_starve < SL)) begin
      m_owner = 2;
      m_wr = dw;
      m_addr = d_pmem_address;
      m_wdata = d_pmem_wdata;
      m_starve = !ir ? 0 : (m_starve < SL ? m_starve + 1 : SL);
    end else if (ir) begin
      m_owner = 1;
      m_wr = 0;
      m_addr = i_pmem_address;
      m_starve = 0;
    end else begin
      m_starve = 0;
    end
    @(posedge clk);
    #1;
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      mem_cnt = 0;
    end else if (pmem_read || pmem_write) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat)
        pmem_resp = 1'b1;
    end else begin
      mem_cnt = 0;
    end
    pmem_rdata = rnd_line();
    if (got_i && i_q.size() != 0)
      void'(i_q.pop_front());
    if (got_d && d_q.size() != 0)
      void'(d_q.pop_front());
    drive();
  endtask

  task automatic run(int bound);
    int n = 0;
    while ((i_q.size() != 0 || d_q.size() != 0 || m_owner != 0) && n < bound) begin
      cycle();
      n++;
    end
    check("timeout", LW'(n < bound), LW'(1));
    cycle();
  endtask

  task automatic push_d(logic rd, logic wr, logic [AW-1:0] a, logic [LW-1:0] w);
    dreq_t r;
    r.rd = rd;
    r.wr = wr;
    r.addr = a;
    r.wdata = w;
    d_q.push_back(r);
  endtask

  initial begin
    int req_cyc, i0, d0;
    logic [7:0] a5;
    reset = 1'b1;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    drive();
    cycle();
    cycle();
    check("rst_addr", LW'(pmem_address), LW'(0));
    check("rst_wdata", pmem_wdata, LW'(0));
    reset = 1'b0;
    drive();
    cycle();

    // lone I fill
    mem_lat = 5;
    i_resps = 0;
    d_resps = 0;
    i_q.push_back(32'h0000_0060);
    req_cyc = cyc + 1;
    drive();
    run(50);
    check("lone_i_latency", LW'(last_i_cyc - req_cyc), LW'(5));
    check("lone_i_pulses", LW'(i_resps), LW'(1));
    check("lone_d_pulses", LW'(d_resps), LW'(0));

    // simultaneous I and D reads
    mem_lat = 3;
    i_q.push_back(32'h100);
    push_d(1'b1, 1'b0, 32'h200, '0);
    drive();
    run(50);
    check("d_before_i", LW'(last_i_cyc > last_d_cyc), LW'(1));
    check("i_after_d_gap", LW'(last_i_cyc - last_d_cyc), LW'(1 + mem_lat));

    // D writeback with scrambled inputs after grant
    mem_lat = 4;
    d0 = d_resps;
    a5 = 8'hA5;
    push_d(1'b0, 1'b1, 32'h400, {32{a5}});
    drive();
    run(50);
    check("wb_pulses", LW'(d_resps - d0), LW'(1));

    // starvation guard
    mem_lat = 2;
    d0 = d_resps;
    i_q.push_back(32'h100);
    for (int k = 0; k < 6; k++)
      push_d(1'b1, 1'b0, AW'(32'h1000 + k * 32), '0);
    drive();
    run(200);
    check("starve_d_first", LW'(d_at_i - d0), LW'(SL));
    check("starve_d_total", LW'(d_resps - d0), LW'(6));

    // reset in the middle of a long I fill
    mem_lat = 10;
    i0 = i_resps;
    i_q.push_back(32'h80);
    drive();
    cycle();
    cycle();
    cycle();
    reset = 1'b1;
    drive();
    cycle();
    reset = 1'b0;
    i_q.delete();
    drive();
    for (int k = 0; k < 12; k++)
      cycle();
    check("abort_no_resp", LW'(i_resps - i0), LW'(0));
    mem_lat = 3;
    d0 = d_resps;
    push_d(1'b1, 1'b0, 32'h300, '0);
    drive();
    run(50);
    check("post_rst_d", LW'(d_resps - d0), LW'(1));

    // stray memory response, then read+write together
    i0 = i_resps;
    d0 = d_resps;
    pmem_resp = 1'b1;
    cycle();
    cycle();
    check("stray_i", LW'(i_resps - i0), LW'(0));
    check("stray_d", LW'(d_resps - d0), LW'(0));
    push_d(1'b1, 1'b1, 32'h500, rnd_line());
    drive();
    run(50);
    check("both_hi_pulses", LW'(d_resps - d0), LW'(1));

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if (m_owner == 0 && $urandom_range(0, 3) == 0)
        mem_lat = $urandom_range(1, 6);
      if (i_q.size() < 2 && $urandom_range(0, 4) == 0)
        i_q.push_back($urandom);
      if (d_q.size() < 2 && $urandom_range(0, 3) == 0)
        push_d($urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 1'b0, $urandom, rnd_line());
      if (d_q.size() != 0 && d_q[d_q.size() - 1].rd == 1'b0)
        d_q[d_q.size() - 1].wr = 1'b1;
      if (m_owner == 0 && i_q.size() == 0 && d_q.size() == 0
          && !pmem_resp && $urandom_range(0, 9) == 0)
        pmem_resp = 1'b1;
      drive();
      cycle();
    end
    run(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
